// File: rtl/mod_sequencer_if.sv
// Request/response handshake plus RAM8 port bundle for mod_sequencer.
// The slave modport is the sequencer; the master modport is its environment (requester and RAM).
interface mod_sequencer_if;
  logic        start;
  logic [15:0] x;
  logic [15:0] y;
  logic        busy;
  logic        done;
  logic [15:0] rem;
  logic [15:0] quo;
  logic        div_zero;
  logic        ram_e;
  logic        ram_w;
  logic        ram_r;
  logic [2:0]  ram_addr;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;

  modport slave (
    input  start, x, y, ram_dout,
    output busy, done, rem, quo, div_zero, ram_e, ram_w, ram_r, ram_addr, ram_din
  );

  modport master (
    output start, x, y, ram_dout,
    input  busy, done, rem, quo, div_zero, ram_e, ram_w, ram_r, ram_addr, ram_din
  );
endinterface

// File: rtl/mod_sequencer.sv
// Sequences a RAM8 register file to compute x mod y (and x / y) by repeated subtraction.
// Define MODSEQ_QUOT_EN to store the quotient at QUO_ADDR and drive it on quo.
module mod_sequencer #(
  parameter logic [2:0] X_ADDR   = 3'd0,
  parameter logic [2:0] Y_ADDR   = 3'd1,
  parameter logic [2:0] REM_ADDR = 3'd2,
  parameter logic [2:0] QUO_ADDR = 3'd3
) (
  input  logic            clk,
  input  logic            re_n,
  mod_sequencer_if.slave  bus
);

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_WR_X = 4'd1;
  localparam logic [3:0] ST_WR_Y = 4'd2;
  localparam logic [3:0] ST_RD_X = 4'd3;
  localparam logic [3:0] ST_RD_Y = 4'd4;
  localparam logic [3:0] ST_SUB  = 4'd5;
  localparam logic [3:0] ST_WR_R = 4'd6;
  localparam logic [3:0] ST_WR_Q = 4'd7;
  localparam logic [3:0] ST_DONE = 4'd8;

  logic [3:0]  state;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] quo_q;
  logic [15:0] rem_q;
  logic        div_zero_q;

  logic        ram_e;
  logic        ram_w;
  logic        ram_r;
  logic [2:0]  ram_addr;
  logic [15:0] ram_din;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge re_n) begin
    if (!re_n) begin
      state      <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      a          <= '0;
      b          <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            x_q        <= bus.x;
            y_q        <= bus.y;
            quo_q      <= '0;
            rem_q      <= '0;
            div_zero_q <= 1'b0;
            state      <= ST_WR_X;
          end
        end
        ST_WR_X: state <= ST_WR_Y;
        ST_WR_Y: state <= ST_RD_X;
        ST_RD_X: begin
          a     <= bus.ram_dout;
          state <= ST_RD_Y;
        end
        ST_RD_Y: begin
          b <= bus.ram_dout;
          if (bus.ram_dout == 16'd0) begin
            div_zero_q <= 1'b1;
            a          <= x_q;
            quo_q      <= 16'hFFFF;
            state      <= ST_WR_R;
          end else begin
            state <= ST_SUB;
          end
        end
        ST_SUB: begin
          // Non-strict compare: a == b takes one more step, leaving remainder 0.
          if (a >= b) begin
            a     <= a - b;
            quo_q <= quo_q + 16'd1;
          end else begin
            state <= ST_WR_R;
          end
        end
        ST_WR_R: begin
          rem_q <= a;
`ifdef MODSEQ_QUOT_EN
          state <= ST_WR_Q;
`else
          state <= ST_DONE;
`endif
        end
        ST_WR_Q: state <= ST_DONE;
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // RAM strobes decode from registered state only, so ram_w cannot glitch and drops with reset.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ram_e    = 1'b0;
    ram_w    = 1'b0;
    ram_r    = 1'b0;
    ram_addr = 3'd0;
    ram_din  = 16'd0;
    case (state)
      ST_WR_X: begin
        ram_e    = 1'b1;
        ram_w    = 1'b1;
        ram_addr = X_ADDR;
        ram_din  = x_q;
      end
      ST_WR_Y: begin
        ram_e    = 1'b1;
        ram_w    = 1'b1;
        ram_addr = Y_ADDR;
        ram_din  = y_q;
      end
      ST_RD_X: begin
        ram_e    = 1'b1;
        ram_r    = 1'b1;
        ram_addr = X_ADDR;
      end
      ST_RD_Y: begin
        ram_e    = 1'b1;
        ram_r    = 1'b1;
        ram_addr = Y_ADDR;
      end
      ST_WR_R: begin
        ram_e    = 1'b1;
        ram_w    = 1'b1;
        ram_addr = REM_ADDR;
        ram_din  = a;
      end
      ST_WR_Q: begin
        ram_e    = 1'b1;
        ram_w    = 1'b1;
        ram_addr = QUO_ADDR;
        ram_din  = quo_q;
      end
      default: ;
    endcase
  end

  assign bus.ram_e    = ram_e;
  assign bus.ram_w    = ram_w;
  assign bus.ram_r    = ram_r;
  assign bus.ram_addr = ram_addr;
  assign bus.ram_din  = ram_din;

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.rem      = rem_q;
  assign bus.div_zero = div_zero_q;
`ifdef MODSEQ_QUOT_EN
  assign bus.quo      = quo_q;
`else
  assign bus.quo      = div_zero_q ? 16'hFFFF : 16'd0;
`endif

endmodule

// File: tb/tb_mod_sequencer.sv
// Self-checking bench for mod_sequencer: directed cases plus randomized operands
// checked against an arithmetic (x / y, x % y) reference model and a RAM8 model.
module tb_mod_sequencer;

  logic clk;
  logic re_n;
  int   tests_run;
  int   fails;

  logic [15:0] mem [8];

  mod_sequencer_if bus ();

  mod_sequencer dut (
    .clk  (clk),
    .re_n (re_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM8 model: combinational read, synchronous write when enabled.
  assign bus.ram_dout = mem[bus.ram_addr];
  always @(posedge clk) begin
    if (bus.ram_e && bus.ram_w) mem[bus.ram_addr] <= bus.ram_din;
  end

  function automatic int exp_latency(input logic [15:0] xv, input logic [15:0] yv);
    int lat;
    lat = (yv == 16'd0) ? 5 : 6 + int'(xv / yv);
`ifdef MODSEQ_QUOT_EN
    lat = lat + 1;
`endif
    return lat;
  endfunction

  function automatic logic [15:0] exp_quo(input logic [15:0] xv, input logic [15:0] yv);
    if (yv == 16'd0) return 16'hFFFF;
`ifdef MODSEQ_QUOT_EN
    return xv / yv;
`else
    return 16'd0;
`endif
  endfunction

  // Runs one operation from an idle DUT and checks latency, outputs and RAM contents.
  task automatic do_divide(input logic [15:0] xv, input logic [15:0] yv, input string tag);
    int          n;
    bit          seen;
    int          lat;
    logic [15:0] er;
    logic [15:0] eq;
    logic [15:0] q_slot;
    q_slot = mem[3];
    lat = exp_latency(xv, yv);
    er  = (yv == 16'd0) ? xv : xv % yv;
    eq  = exp_quo(xv, yv);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.y     = yv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x     = 16'($urandom);
    bus.y     = 16'($urandom);
    n = 0;
    seen = 0;
    while (!seen && n < 70000) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) seen = 1;
    end
    tests_run++;
    if (n !== lat || !seen) begin
      fails++;
      $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", tag, n, seen, lat);
    end
    tests_run++;
    if (bus.rem !== er) begin
      fails++;
      $display("FAIL %s rem: got %0d expected %0d", tag, bus.rem, er);
    end
    tests_run++;
    if (bus.quo !== eq) begin
      fails++;
      $display("FAIL %s quo: got %h expected %h", tag, bus.quo, eq);
    end
    tests_run++;
    if (bus.div_zero !== (yv == 16'd0)) begin
      fails++;
      $display("FAIL %s div_zero: got %b expected %b", tag, bus.div_zero, yv == 16'd0);
    end
    tests_run++;
    if (mem[0] !== xv || mem[1] !== yv || mem[2] !== er) begin
      fails++;
      $display("FAIL %s ram x/y/rem: got %0d/%0d/%0d expected %0d/%0d/%0d",
               tag, mem[0], mem[1], mem[2], xv, yv, er);
    end
`ifdef MODSEQ_QUOT_EN
    q_slot = eq;
`endif
    tests_run++;
    if (mem[3] !== q_slot) begin
      fails++;
      $display("FAIL %s ram quo slot: got %h expected %h", tag, mem[3], q_slot);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s after done: done=%b busy=%b expected 0/0", tag, bus.done, bus.busy);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests_run++;
    if ({bus.busy, bus.done, bus.div_zero, bus.ram_e, bus.ram_w, bus.ram_r, bus.ram_addr} !== 9'd0) begin
      fails++;
      $display("FAIL %s ctrl: got busy=%b done=%b dz=%b e=%b w=%b r=%b addr=%0d expected all 0",
               tag, bus.busy, bus.done, bus.div_zero, bus.ram_e, bus.ram_w, bus.ram_r, bus.ram_addr);
    end
    tests_run++;
    if (bus.rem !== 16'd0 || bus.quo !== 16'd0 || bus.ram_din !== 16'd0) begin
      fails++;
      $display("FAIL %s data: got rem=%h quo=%h din=%h expected 0", tag, bus.rem, bus.quo, bus.ram_din);
    end
  endtask

  task automatic test_reset();
    re_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    re_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_divide(16'd100,   16'd7,     "x100_y7");
    do_divide(16'd5,     16'd9,     "x5_y9");
    do_divide(16'd12,    16'd12,    "x12_y12");
    do_divide(16'd1234,  16'd0,     "x1234_y0");
    do_divide(16'd0,     16'd5,     "x0_y5");
    do_divide(16'hFFFF,  16'hFFFF,  "xmax_ymax");
    do_divide(16'hFFFF,  16'h8000,  "xmax_yhalf");
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 16'd1000;
    bus.y     = 16'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    re_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_sub");
    @(negedge clk);
    re_n = 1'b1;
    do_divide(16'd10, 16'd4, "after_reset");
  endtask

  task automatic test_start_while_busy();
    int n;
    int done_cnt;
    int first_done;
    int lat;
    lat = exp_latency(16'd200, 16'd9);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 16'd200;
    bus.y     = 16'd9;
    @(posedge clk);
    #1;
    bus.x = 16'd50;
    bus.y = 16'd3;
    done_cnt = 0;
    first_done = -1;
    for (n = 1; n <= lat + 8; n++) begin
      @(posedge clk);
      #1;
      if (n == 8) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (first_done < 0) first_done = n;
      end
    end
    tests_run++;
    if (done_cnt !== 1 || first_done !== lat) begin
      fails++;
      $display("FAIL busy_start done: got %0d pulses first at %0d expected 1 at %0d",
               done_cnt, first_done, lat);
    end
    tests_run++;
    if (bus.rem !== 16'd2 || mem[0] !== 16'd200) begin
      fails++;
      $display("FAIL busy_start rem: got rem=%0d ram_x=%0d expected 2/200", bus.rem, mem[0]);
    end
  endtask

  task automatic test_random();
    logic [15:0] xv;
    logic [15:0] yv;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        yv = 16'($urandom_range(65535, 16));
        xv = 16'($urandom_range(65535, 0));
      end else begin
        yv = 16'($urandom_range(15, 1));
        xv = 16'($urandom_range(2000, 0));
      end
      do_divide(xv, yv, $sformatf("rand%0d_x%0d_y%0d", i, xv, yv));
    end
  endtask

  initial begin
    tests_run = 0;
    fails     = 0;
    bus.start = 1'b0;
    bus.x     = 16'd0;
    bus.y     = 16'd0;
    for (int i = 0; i < 8; i++) mem[i] = 16'hA5A5;
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/mod_sequencer.md
# mod_sequencer

Clocked controller that sequences the 8x16 RAM8 register file to compute 16-bit unsigned `x mod y` and the matching quotient by repeated subtraction. It replaces ad-hoc `always`/`#delay` sequencing with a synchronous FSM and a start/done handshake. The block sits between a requester and one RAM8 instance, and owns all of that RAM's `e`, `DIn`, `addr`, `w` and `r` inputs.

## Interface
Parameters:
- `X_ADDR`, default 3'd0: RAM slot holding the operand x.
- `Y_ADDR`, default 3'd1: RAM slot holding the operand y.
- `REM_ADDR`, default 3'd2: RAM slot receiving the remainder.
- `QUO_ADDR`, default 3'd3: RAM slot receiving the quotient (used only with `MODSEQ_QUOT_EN`).

Ports:
- `clk` in 1: single clock, rising edge.
- `re_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `x` in 16: dividend; latched on the accepting edge.
- `y` in 16: divisor; latched on the accepting edge.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when results are valid.
- `rem` out 16: remainder; held until the next accepted start.
- `quo` out 16: quotient; held until the next accepted start.
- `div_zero` out 1: y was 0; held until the next accepted start.
- `ram_e`, `ram_w`, `ram_r` out 1: RAM8 enable, write and read.
- `ram_addr` out 3: RAM8 address.
- `ram_din` out 16: RAM8 write data.
- `ram_dout` in 16: RAM8 read data.

## Operation
- FSM states: IDLE, WR_X, WR_Y, RD_X, RD_Y, SUB, WR_R, WR_Q, DONE.
- IDLE: `start`=1 latches x and y, clears `quo`, `rem` and `div_zero`, then goes to WR_X. While `busy`=1, `start` is ignored.
- WR_X / WR_Y: `ram_e`=1, `ram_w`=1, `ram_r`=0. Address is `X_ADDR` / `Y_ADDR`; data is the latched x / y.
- RD_X / RD_Y: `ram_e`=1, `ram_r`=1, `ram_w`=0. Address is `X_ADDR` / `Y_ADDR`.
  - `ram_dout` is combinational in the address.
  - The edge leaving the state captures the working register `a` (from RD_X) or `b` (from RD_Y).
- Leaving RD_Y: if b==0, set `div_zero`=1, `a`=x, `quo`=16'hFFFF, and go to WR_R. Otherwise go to SUB.
- SUB, one edge per step:
  - If a>=b: `a`←a−b and `quo`←quo+1 (16-bit, cannot overflow because b≥1).
  - Otherwise go to WR_R.
- Comparison is unsigned and non-strict. a==b yields remainder 0 and quotient 1.
- WR_R: write `a` to `REM_ADDR`, and set `rem`←a. Next state is WR_Q with `MODSEQ_QUOT_EN`, else DONE.
- WR_Q: write `quo` to `QUO_ADDR`, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- RAM outputs in IDLE, SUB and DONE: `ram_e`=`ram_w`=`ram_r`=0, `ram_addr`=0, `ram_din`=0.
- All RAM outputs are decoded from registered state only (glitch-free `ram_w`).

## Timing
- Reset (`re_n`=0, takes effect immediately): state IDLE. `busy`, `done`, `div_zero`, `ram_e`, `ram_w` and `ram_r` are 0; `rem`, `quo`, `ram_addr` and `ram_din` are 0. RAM contents are not cleared.
- Reset mid-operation aborts the operation. An in-flight write is dropped because `ram_w` falls asynchronously. The first `start` after release is accepted normally.
- Edges are counted from E0, the edge that accepts `start`:
  - WR_X after E0, WR_Y after E1, RD_X after E2, RD_Y after E3, SUB after E4.
  - SUB lasts q+1 cycles, where q is the quotient.
  - WR_R after E(5+q).
  - `done` is high after E(6+q) without the macro, and after E(7+q) with it.
- y==0: `done` is high after E5 without the macro, E6 with it.
- Worst case is y=1, x=65535: 65541 cycles without the macro.
- `start` held high through DONE re-arms on the first IDLE cycle; there is no back-to-back acceptance in the DONE cycle.

## Configuration
- `MODSEQ_QUOT_EN` defined: WR_Q exists, the quotient is stored at `QUO_ADDR`, and `quo` is driven. Latency is +1 cycle.
- `MODSEQ_QUOT_EN` undefined: WR_Q is removed and the quotient counter is still used internally. `quo` is tied to 0, except that it is 16'hFFFF on `div_zero`. `QUO_ADDR` is never written.

## Test plan
- x=100, y=7 → `rem`=2, `div_zero`=0, RAM[2]=2, `done` 20 cycles after E0. With the macro: `quo`=14, RAM[3]=14, `done` after 21 cycles.
- x=5, y=9 → `rem`=5, `quo`=0, `done` after 6 (macro 7) cycles.
- x=12, y=12 → `rem`=0, `quo`=1 (with the macro); confirms the non-strict compare.
- x=1234, y=0 → `div_zero`=1, `rem`=1234, `quo`=16'hFFFF, RAM[2]=1234, `done` after 5 (macro 6).
- Start x=1000, y=3; pulse `re_n` low during SUB → all outputs 0 immediately and IDLE. Then start x=10, y=4 → `rem`=2.
- Pulse `start` again during `busy` with different x/y → ignored; the result matches the first operands, and `done` pulses exactly once.
